// File: rtl/pwm_fade_ctrl_if.sv
// Button-to-PWM brightness bus: raw button in, compare value, load strobe and status out.
interface pwm_fade_ctrl_if;
   logic        pb_in;
   logic [15:0] duty_n;
   logic        load;
   logic [2:0]  level;
   logic        ramping;

   modport master (output pb_in, input duty_n, load, level, ramping);
   modport slave  (input pb_in, output duty_n, load, level, ramping);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Debounced push-button brightness stepper that ramps the PWM compare value
// toward a per-level target in clamped STEP increments every RAMP_DIV cycles.
module pwm_fade_ctrl #(
   parameter int unsigned DB_CYCLES = 50000,
   parameter int unsigned RAMP_DIV  = 1000,
   parameter int unsigned STEP      = 256
) (
   input  logic            clk,
   input  logic            rst,
   pwm_fade_ctrl_if.slave  bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RAMP = 1'b1;
   localparam int         DBW    = 21;
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
   localparam logic [15:0]    DIV_LAST = 16'(RAMP_DIV - 1);
   localparam logic [16:0]    STEP17   = 17'(STEP);

   logic           s1_q, s1_d, s2_q, s2_d;
   logic           db_q, db_d, db_prev_q, db_prev_d;
   logic [DBW-1:0] db_cnt_q, db_cnt_d;
   logic [15:0]    div_q, div_d;
   logic [15:0]    target_q, target_d;
   logic [15:0]    duty_q, duty_d;
   logic           load_q, load_d;
   logic [2:0]     level_q, level_d;
   logic           ramping_q, ramping_d;
   logic [0:0]     state_q, state_d;

   logic           press, tick;
   logic [2:0]     new_level;
   logic [15:0]    new_target, next_duty;
   logic [16:0]    up_sum, dn_diff;

   // Clamped step toward target; 17-bit math so carry/borrow flags the clamp.
   always_comb begin
      up_sum    = {1'b0, duty_q} + STEP17;
      dn_diff   = {1'b0, duty_q} - STEP17;
      next_duty = duty_q;
      if (duty_q < target_q)
         next_duty = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[15:0];
      else if (duty_q > target_q)
         next_duty = (dn_diff[16] || (dn_diff[15:0] < target_q)) ? target_q : dn_diff[15:0];
   end

   always_comb begin
      s1_d      = bus.pb_in;
      s2_d      = s1_q;
      db_d      = db_q;
      db_cnt_d  = '0;
      if (s2_q != db_q) begin
         if (db_cnt_q == DB_LAST) db_d = s2_q;
         else                     db_cnt_d = db_cnt_q + 1'b1;
      end
      db_prev_d = db_q;

      press      = db_q & ~db_prev_q;
      tick       = (div_q == DIV_LAST);
      new_level  = level_q + 3'd1;
      new_target = {new_level, 13'd0};

      level_d   = level_q;
      target_d  = target_q;
      div_d     = div_q;
      duty_d    = duty_q;
      load_d    = 1'b0;
      ramping_d = ramping_q;
      state_d   = state_q;

      // A press always wins over a coincident tick: the ramp restarts its divider.
      if (press) begin
         level_d  = new_level;
         target_d = new_target;
         div_d    = '0;
         if (new_target == duty_q) begin
            ramping_d = 1'b0;
            state_d   = S_IDLE;
         end else begin
            ramping_d = 1'b1;
            state_d   = S_RAMP;
         end
      end else if (state_q == S_RAMP) begin
         if (tick) begin
            div_d  = '0;
            duty_d = next_duty;
            load_d = 1'b1;
            if (next_duty == target_q) begin
               ramping_d = 1'b0;
               state_d   = S_IDLE;
            end
         end else begin
            div_d = div_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         db_cnt_q  <= '0;
         div_q     <= '0;
         target_q  <= '0;
         duty_q    <= '0;
         load_q    <= 1'b0;
         level_q   <= '0;
         ramping_q <= 1'b0;
         state_q   <= S_IDLE;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         db_cnt_q  <= db_cnt_d;
         div_q     <= div_d;
         target_q  <= target_d;
         duty_q    <= duty_d;
         load_q    <= load_d;
         level_q   <= level_d;
         ramping_q <= ramping_d;
         state_q   <= state_d;
      end
   end

   assign bus.duty_n  = duty_q;
   assign bus.load    = load_q;
   assign bus.level   = level_q;
   assign bus.ramping = ramping_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench: per-cycle comparison against a behavioural model built
// from the press/ramp rules (sample history window, absolute tick schedule).
module tb_pwm_fade_ctrl;
   localparam int DB = 4;
   localparam int RD = 2;
   localparam int ST = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   pwm_fade_ctrl_if bus ();

   pwm_fade_ctrl #(.DB_CYCLES(DB), .RAMP_DIV(RD), .STEP(ST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state
   int m_s1 = 0, m_s2 = 0, m_db = 0, m_dbp = 0;
   int hist[$];
   int m_level = 0, m_duty = 0, m_target = 0, m_load = 0, m_ramp = 0;
   int m_next_tick = 0;
   int cyc = 0;

   task automatic step(input bit pb, input bit r);
      int  press, new_db;
      bit  all_diff;
      bus.pb_in = pb;
      rst       = r;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; hist.delete();
         m_level = 0; m_duty = 0; m_target = 0; m_load = 0; m_ramp = 0;
      end else begin
         press = (m_db == 1 && m_dbp == 0);
         // db follows s2 once the last DB synchronized samples all disagree with it
         hist.push_back(m_s2);
         if (hist.size() > DB) void'(hist.pop_front());
         new_db = m_db;
         all_diff = (hist.size() == DB);
         foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
         if (all_diff) begin new_db = m_s2; hist.delete(); end
         m_dbp = m_db; m_db = new_db; m_s2 = m_s1; m_s1 = pb;
         m_load = 0;
         if (press) begin
            m_level  = (m_level + 1) % 8;
            m_target = m_level * 8192;
            if (m_target == m_duty) m_ramp = 0;
            else begin m_ramp = 1; m_next_tick = cyc + RD; end
         end else if (m_ramp == 1 && cyc == m_next_tick) begin
            if (m_duty < m_target) m_duty = (m_duty + ST > m_target) ? m_target : m_duty + ST;
            else                   m_duty = (m_duty - ST < m_target) ? m_target : m_duty - ST;
            m_load = 1;
            if (m_duty == m_target) m_ramp = 0;
            else m_next_tick = cyc + RD;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(i[0], 1'b1);
         checks++;
         if (bus.duty_n !== 16'd0 || bus.load !== 1'b0 || bus.level !== 3'd0 || bus.ramping !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d got duty=%0d load=%b level=%0d ramping=%b want all 0",
                     cyc, bus.duty_n, bus.load, bus.level, bus.ramping);
         end
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0);
         checks++;
         if (bus.duty_n !== 16'd0 || bus.load !== 1'b0 || bus.level !== 3'd0 || bus.ramping !== 1'b0) begin
            errors++;
            $display("FAIL reset_after cyc %0d got duty=%0d load=%b level=%0d ramping=%b want all 0",
                     cyc, bus.duty_n, bus.load, bus.level, bus.ramping);
         end
      end
   endtask

   task automatic test_single_press();
      for (int e = 1; e <= 12; e++) begin
         step(1'b1, 1'b0);
         checks++;
         if (bus.duty_n !== m_duty[15:0] || bus.load !== m_load[0] || bus.level !== m_level[2:0] || bus.ramping !== m_ramp[0]) begin
            errors++;
            $display("FAIL single_model edge %0d got duty=%0d load=%b level=%0d ramping=%b want %0d %0d %0d %0d",
                     e, bus.duty_n, bus.load, bus.level, bus.ramping, m_duty, m_load, m_level, m_ramp);
         end
         if (e == 6 || e == 7) begin
            checks++;
            if (bus.level !== ((e == 7) ? 3'd1 : 3'd0)) begin
               errors++;
               $display("FAIL single_level edge %0d got %0d want %0d", e, bus.level, (e == 7) ? 1 : 0);
            end
         end
         if (e == 9 || e == 11) begin
            checks++;
            if (bus.duty_n !== ((e == 9) ? 16'd4096 : 16'd8192) || bus.load !== 1'b1 ||
                bus.ramping !== ((e == 9) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL single_write edge %0d got duty=%0d load=%b ramping=%b want %0d 1 %0d",
                        e, bus.duty_n, bus.load, bus.ramping, (e == 9) ? 4096 : 8192, (e == 9) ? 1 : 0);
            end
         end
         if (e == 10 || e == 12) begin
            checks++;
            if (bus.load !== 1'b0) begin
               errors++;
               $display("FAIL single_load_width edge %0d got load=%b want 0", e, bus.load);
            end
         end
      end
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
   endtask

   task automatic test_glitch();
      int lvl0, dty0;
      lvl0 = m_level; dty0 = m_duty;
      for (int i = 0; i < 15; i++) begin
         step(i < 3, 1'b0);
         checks++;
         if (bus.level !== lvl0[2:0] || bus.duty_n !== dty0[15:0] || bus.load !== 1'b0) begin
            errors++;
            $display("FAIL glitch cyc %0d got level=%0d duty=%0d load=%b want %0d %0d 0",
                     cyc, bus.level, bus.duty_n, bus.load, lvl0, dty0);
         end
      end
   endtask

   // one clean press followed by a long release, checked against the model
   task automatic press_and_wait(input int low_cycles);
      for (int i = 0; i < 6 + low_cycles; i++) begin
         step(i < 6, 1'b0);
         checks++;
         if (bus.duty_n !== m_duty[15:0] || bus.load !== m_load[0] || bus.level !== m_level[2:0] || bus.ramping !== m_ramp[0]) begin
            errors++;
            $display("FAIL press_model cyc %0d got duty=%0d load=%b level=%0d ramping=%b want %0d %0d %0d %0d",
                     cyc, bus.duty_n, bus.load, bus.level, bus.ramping, m_duty, m_load, m_level, m_ramp);
         end
      end
   endtask

   task automatic test_wrap();
      int guard, loads, prev;
      guard = 0;
      while (m_level != 7 && guard < 10) begin press_and_wait(14); guard++; end
      checks++;
      if (bus.level !== 3'd7 || bus.duty_n !== 16'd57344) begin
         errors++;
         $display("FAIL wrap_top got level=%0d duty=%0d want 7 57344", bus.level, bus.duty_n);
      end
      loads = 0; prev = 57344;
      for (int i = 0; i < 45; i++) begin
         step(i < 6, 1'b0);
         if (bus.load === 1'b1) begin
            loads++;
            checks++;
            if (bus.duty_n !== 16'(prev - 4096)) begin
               errors++;
               $display("FAIL wrap_step got duty=%0d want %0d", bus.duty_n, prev - 4096);
            end
            prev = prev - 4096;
         end
      end
      checks++;
      if (loads != 14 || bus.level !== 3'd0 || bus.duty_n !== 16'd0 || bus.ramping !== 1'b0) begin
         errors++;
         $display("FAIL wrap_end got loads=%0d level=%0d duty=%0d ramping=%b want 14 0 0 0",
                  loads, bus.level, bus.duty_n, bus.ramping);
      end
   endtask

   task automatic test_retarget();
      int guard, min_seen, loads;
      guard = 0;
      while (m_level != 7 && guard < 10) begin press_and_wait(14); guard++; end
      // press to 0 (long ramp down), second press lands mid-ramp and retargets to 8192
      min_seen = 65535; loads = 0;
      for (int i = 0; i < 60; i++) begin
         step((i < 6) || (i >= 12 && i < 18), 1'b0);
         if (bus.load === 1'b1) loads++;
         if (i >= 25 && bus.duty_n < min_seen) min_seen = bus.duty_n;
         checks++;
         if (bus.duty_n !== m_duty[15:0] || bus.load !== m_load[0] || bus.level !== m_level[2:0] || bus.ramping !== m_ramp[0]) begin
            errors++;
            $display("FAIL retarget_model cyc %0d got duty=%0d load=%b level=%0d ramping=%b want %0d %0d %0d %0d",
                     cyc, bus.duty_n, bus.load, bus.level, bus.ramping, m_duty, m_load, m_level, m_ramp);
         end
      end
      checks++;
      if (bus.level !== 3'd1 || bus.duty_n !== 16'd8192 || min_seen != 8192 || loads != 12) begin
         errors++;
         $display("FAIL retarget_end got level=%0d duty=%0d min=%0d loads=%0d want 1 8192 8192 12",
                  bus.level, bus.duty_n, min_seen, loads);
      end
   endtask

   task automatic test_reset_mid_ramp();
      bit seen;
      step(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b1, 1'b0);
         if (bus.duty_n === 16'd4096) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midramp_reach got duty=%0d want 4096 within 20 cycles", bus.duty_n);
      end
      step(1'b0, 1'b1);
      checks++;
      if (bus.duty_n !== 16'd0 || bus.load !== 1'b0 || bus.level !== 3'd0 || bus.ramping !== 1'b0) begin
         errors++;
         $display("FAIL midramp_reset got duty=%0d load=%b level=%0d ramping=%b want all 0",
                  bus.duty_n, bus.load, bus.level, bus.ramping);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         checks++;
         if (bus.load !== 1'b0 || bus.duty_n !== 16'd0) begin
            errors++;
            $display("FAIL midramp_quiet cyc %0d got load=%b duty=%0d want 0 0", cyc, bus.load, bus.duty_n);
         end
      end
   endtask

   task automatic test_held_through_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 25; i++) step(i < 12, 1'b0);
      checks++;
      if (bus.level !== 3'd1 || bus.duty_n !== 16'd8192) begin
         errors++;
         $display("FAIL held_reset got level=%0d duty=%0d want 1 8192", bus.level, bus.duty_n);
      end
   endtask

   task automatic test_random();
      bit pb, r;
      int run;
      pb = 0; run = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run == 0) begin pb = ~pb; run = $urandom_range(12, 1); end
         run--;
         r = ($urandom_range(299, 0) == 0);
         step(pb, r);
         checks++;
         if (bus.duty_n !== m_duty[15:0] || bus.load !== m_load[0] || bus.level !== m_level[2:0] || bus.ramping !== m_ramp[0]) begin
            errors++;
            if (errors < 30)
               $display("FAIL random cyc %0d got duty=%0d load=%b level=%0d ramping=%b want %0d %0d %0d %0d",
                        cyc, bus.duty_n, bus.load, bus.level, bus.ramping, m_duty, m_load, m_level, m_ramp);
         end
      end
   endtask

   initial begin
      bus.pb_in = 1'b0;
      test_reset();
      test_single_press();
      test_glitch();
      test_wrap();
      test_retarget();
      test_reset_mid_ramp();
      test_held_through_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
